link_capture_ctrl: RTL
======================

// Module: link_capture_ctrl
// PURPOSE
//  Capture sequencer for one link: consumes the control word delivered into the link clock domain by the
//  register CDC stage, arms on a start edge, waits for a qualifier (immediate / align word / trigger),
//  then writes N consecutive valid link words into a capture BRAM. Status word goes back to the AXI side via the CDC stage.
// PARAMETERS
//  DATA_WIDTH   32            link word / BRAM data width
//  ADDR_WIDTH   10            BRAM address width; depth = 2**ADDR_WIDTH; legal range 1..15
//  ALIGN_WORD   32'h9CCCCCCC  qualifier pattern for mode 1 (compared over DATA_WIDTH bits)
// PORTS
//  clk          in   1              link clock; all logic on posedge
//  resetn       in   1              synchronous, active-low reset
//  ctrl_reg     in   32             [0] start (rising edge arms), [1] stop/abort (level), [3:2] mode, [31:16] length
//  link_data    in   DATA_WIDTH     link word
//  link_valid   in   1              link_data valid this cycle
//  trigger_in   in   1              external trigger, qualifier for mode 2 (single-cycle pulse or level)
//  bram_we      out  1              capture BRAM write enable
//  bram_addr    out  ADDR_WIDTH     capture BRAM address
//  bram_din     out  DATA_WIDTH     capture BRAM write data
//  status_reg   out  32             [0] busy [1] done [2] armed [3] aborted [15:4] 0 [31:16] words written
//  trig_ts      out  32             only with LINK_CAPTURE_TS_EN: cycle stamp of qualifying word
// BEHAVIOUR
//  Reset (resetn=0 at posedge): state IDLE; bram_we=0, bram_addr=0, bram_din=0, status_reg=0, trig_ts=0,
//   start-edge history cleared (start held high through reset does not arm). Mid-capture reset abandons capture, no further writes.
//  Start edge: ctrl_reg[0] registered; edge = bit high now, low in previous cycle. ctrl_reg may change on any cycle.
//  Length: L = ctrl_reg[31:16] latched on start edge; L=0 or L>depth -> L=depth. Mode 3 is treated as mode 0.
//  FSM: IDLE -(start edge)-> ARMED -(qualifying word)-> CAPTURE -(L words written)-> DONE -(start edge)-> ARMED.
//   Qualifying word (ARMED, link_valid=1): mode0 any word; mode1 link_data==ALIGN_WORD; mode2 trigger_in=1 same cycle.
//   Qualifying word is word 0 and is written. In CAPTURE each link_valid=1 cycle writes one word; link_valid=0 pauses, addr holds.
//  Write timing: word sampled at cycle t appears as bram_we=1, bram_din=word, bram_addr=k at t+1 (one-cycle registered latency).
//  Addresses 0..L-1 strictly increasing, no wrap; after word L-1 FSM enters DONE, bram_we=0 next cycle.
//  stop (ctrl_reg[1]=1) in ARMED/CAPTURE: -> IDLE, aborted=1, no further writes (a write already registered completes). Stop wins over a same-cycle start edge.
//  Start edge in ARMED/CAPTURE ignored. Start edge in IDLE/DONE clears done, aborted and word count, relatches mode/L.
//  status: busy=(ARMED|CAPTURE); armed=ARMED; done sticky in DONE; word count = words written (0..depth), registered, zero-extended.
// CONFIGURATION
//  LINK_CAPTURE_TS_EN defined: 32-bit free-running cycle counter (wraps 0xFFFFFFFF->0, reset to 0); value at
//   qualifying word latched into trig_ts, held until next qualifying word or reset.
//  Undefined: counter and trig_ts port absent; all other behaviour identical.
// STRUCTURE
//  Package link_capture_pkg: state enum (IDLE, ARMED, CAPTURE, DONE), mode constants (MODE_IMM=0, MODE_ALIGN=1,
//   MODE_TRIG=2), ctrl_reg/status_reg bit-field index constants.
//  Sub-module link_capture_qual: combinational/registered qualifier select (mode, link_data, link_valid, trigger_in -> qualify).
// TESTING
//  Mode0, L=4, link_valid always 1, words 0x10..0x17 after arm -> writes addr0..3 = 0x10..0x13, done=1, count=4.
//  Mode1, L=3, stream 1,2,ALIGN_WORD,5,6,7 -> addr0=ALIGN_WORD, addr1=5, addr2=6; no write before match.
//  Mode2, L=2, link_valid gapped 1,0,1 after trigger -> 2 writes, addr holds across gap, bram_we low on gap+1.
//  L=0 with ADDR_WIDTH=4 -> exactly 16 writes addr 0..15, no wrap; L=0x8000 -> also clamped to 16.
//  Stop asserted after 5 of 8 words -> IDLE, aborted=1, count=5, no further bram_we; start+stop same cycle -> stays IDLE.
//  Reset mid-CAPTURE with start held high -> all outputs 0, no re-arm until start falls and rises again.

Source files
------------

// File: rtl/link_capture_pkg.sv
// ---------------------------------------------------------------------------
// link_capture_pkg
// Shared types and constants for the link capture sequencer:
//   - cap_state_e : sequencer states (IDLE, ARMED, CAPTURE, DONE)
//   - MODE_*      : qualifier modes carried in ctrl_reg[3:2]
//   - CTRL_* / STAT_* : bit positions inside ctrl_reg / status_reg
//   - norm_mode() : folds the reserved mode 3 onto immediate mode
// ---------------------------------------------------------------------------
package link_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_e;

  localparam logic [1:0] MODE_IMM   = 2'd0;
  localparam logic [1:0] MODE_ALIGN = 2'd1;
  localparam logic [1:0] MODE_TRIG  = 2'd2;

  // ctrl_reg fields
  localparam int CTRL_START    = 0;
  localparam int CTRL_STOP     = 1;
  localparam int CTRL_MODE_LSB = 2;
  localparam int CTRL_MODE_MSB = 3;
  localparam int CTRL_LEN_LSB  = 16;
  localparam int CTRL_LEN_MSB  = 31;

  // status_reg fields
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ARMED   = 2;
  localparam int STAT_ABORTED = 3;
  localparam int STAT_CNT_LSB = 16;
  localparam int STAT_CNT_MSB = 31;

  // Mode 3 is reserved and behaves exactly like immediate mode.
  function automatic logic [1:0] norm_mode(input logic [1:0] mode);
    return (mode == 2'd3) ? MODE_IMM : mode;
  endfunction

endpackage

// File: rtl/link_capture_qual.sv
// ---------------------------------------------------------------------------
// link_capture_qual
// Combinational qualifier select: decides whether the current link word
// may start a capture.
//   mode_i       in  2   latched capture mode (MODE_IMM / MODE_ALIGN / MODE_TRIG)
//   link_data_i  in  DW  current link word
//   link_valid_i in  1   link word valid this cycle
//   trigger_i    in  1   external trigger (mode 2 qualifier)
//   qualify_o    out 1   this word is the first word of a capture
// ---------------------------------------------------------------------------
module link_capture_qual
  import link_capture_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] ALIGN_WORD = DATA_WIDTH'(32'h9CCCCCCC)
) (
  input  logic [1:0]            mode_i,
  input  logic [DATA_WIDTH-1:0] link_data_i,
  input  logic                  link_valid_i,
  input  logic                  trigger_i,
  output logic                  qualify_o
);

  // NOTE: every output of an always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    qualify_o = 1'b0;
    case (mode_i)
      MODE_ALIGN: qualify_o = link_valid_i && (link_data_i == ALIGN_WORD);
      MODE_TRIG:  qualify_o = link_valid_i && trigger_i;
      default:    qualify_o = link_valid_i;  // immediate (and reserved mode 3)
    endcase
  end

endmodule

// File: rtl/link_capture_ctrl.sv
// ---------------------------------------------------------------------------
// link_capture_ctrl
// Capture sequencer for one link. Arms on a rising edge of ctrl_reg[0],
// waits for a qualifying word, then writes L consecutive valid link words
// into a capture BRAM at addresses 0..L-1.
//
// Optional feature: define LINK_CAPTURE_TS_EN to add a free-running 32-bit
// cycle counter and the trig_ts output (counter value at the qualifying word).
//
// Ports
//   clk        in   1    link clock, posedge
//   resetn     in   1    synchronous active-low reset
//   ctrl_reg   in   32   [0] start (rising edge) [1] stop [3:2] mode [31:16] length
//   link_data  in   DW   link word
//   link_valid in   1    link word valid
//   trigger_in in   1    mode-2 qualifier
//   bram_we    out  1    BRAM write enable
//   bram_addr  out  AW   BRAM address
//   bram_din   out  DW   BRAM write data
//   status_reg out  32   [0] busy [1] done [2] armed [3] aborted [31:16] words written
//   trig_ts    out  32   (LINK_CAPTURE_TS_EN only) cycle stamp of qualifying word
// ---------------------------------------------------------------------------
module link_capture_ctrl
  import link_capture_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 10,
  parameter logic [DATA_WIDTH-1:0] ALIGN_WORD = DATA_WIDTH'(32'h9CCCCCCC)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [31:0]           ctrl_reg,
  input  logic [DATA_WIDTH-1:0] link_data,
  input  logic                  link_valid,
  input  logic                  trigger_in,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  output logic [31:0]           status_reg
`ifdef LINK_CAPTURE_TS_EN
  ,
  output logic [31:0]           trig_ts
`endif
);

  localparam logic [15:0] DEPTH = 16'(32'd1 << ADDR_WIDTH);

  cap_state_e            state_q;
  logic                  start_q;
  logic [1:0]            mode_q;
  logic [15:0]           len_q;
  logic [15:0]           cnt_q;
  logic                  done_q;
  logic                  aborted_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] din_q;

  logic        start_edge;
  logic        stop_req;
  logic        qualify;
  logic        take_word;
  logic [1:0]  mode_d;
  logic [15:0] len_field;
  logic [15:0] len_d;
  logic [15:0] cnt_d;
  logic        unused_ctrl;

  assign unused_ctrl = ^ctrl_reg[15:4];

  assign start_edge = ctrl_reg[CTRL_START] && !start_q;
  assign stop_req   = ctrl_reg[CTRL_STOP];
  assign mode_d     = norm_mode(ctrl_reg[CTRL_MODE_MSB:CTRL_MODE_LSB]);
  assign len_field  = ctrl_reg[CTRL_LEN_MSB:CTRL_LEN_LSB];
  // Zero or oversize length means "fill the whole BRAM".
  assign len_d      = (len_field == 16'd0 || len_field > DEPTH) ? DEPTH : len_field;
  assign cnt_d      = cnt_q + 16'd1;

  link_capture_qual #(
    .DATA_WIDTH (DATA_WIDTH),
    .ALIGN_WORD (ALIGN_WORD)
  ) u_qual (
    .mode_i       (mode_q),
    .link_data_i  (link_data),
    .link_valid_i (link_valid),
    .trigger_i    (trigger_in),
    .qualify_o    (qualify)
  );

  // A word is stored when it qualifies in ARMED, or is valid in CAPTURE.
  assign take_word = ((state_q == ARMED) && qualify) ||
                     ((state_q == CAPTURE) && link_valid);

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      // Track the start bit through reset so a start held high across reset
      // does not look like a fresh edge afterwards.
      start_q   <= ctrl_reg[CTRL_START];
      mode_q    <= MODE_IMM;
      len_q     <= DEPTH;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
    end else begin
      start_q <= ctrl_reg[CTRL_START];
      we_q    <= 1'b0;  // a write lasts exactly one cycle
      case (state_q)
        IDLE, DONE: begin
          // Stop wins over a same-cycle start edge.
          if (start_edge && !stop_req) begin
            state_q   <= ARMED;
            mode_q    <= mode_d;
            len_q     <= len_d;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
          end
        end
        ARMED, CAPTURE: begin
          if (stop_req) begin
            state_q   <= IDLE;
            aborted_q <= 1'b1;
          end else if (take_word) begin
            we_q    <= 1'b1;
            addr_q  <= cnt_q[ADDR_WIDTH-1:0];
            din_q   <= link_data;
            cnt_q   <= cnt_d;
            if (cnt_d == len_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= CAPTURE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bram_we   = we_q;
  assign bram_addr = addr_q;
  assign bram_din  = din_q;

  always_comb begin
    status_reg                             = '0;
    status_reg[STAT_BUSY]                  = (state_q == ARMED) || (state_q == CAPTURE);
    status_reg[STAT_DONE]                  = done_q;
    status_reg[STAT_ARMED]                 = (state_q == ARMED);
    status_reg[STAT_ABORTED]               = aborted_q;
    status_reg[STAT_CNT_MSB:STAT_CNT_LSB]  = cnt_q;
  end

`ifdef LINK_CAPTURE_TS_EN
  logic [31:0] ts_cnt_q;
  logic [31:0] trig_ts_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ts_cnt_q  <= '0;
      trig_ts_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 32'd1;
      if ((state_q == ARMED) && !stop_req && qualify) begin
        trig_ts_q <= ts_cnt_q;
      end
    end
  end

  assign trig_ts = trig_ts_q;
`endif

endmodule
